// File: rtl/serial_loader_pkg.sv
// Shared definitions for the serial boot loader.
//   state_t     : frame parser states
//   ERR_*       : err_code values reported by serial_loader
//   SYNC_BYTE   : default frame start marker
package serial_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_LEN     = 3'd2,
        ST_DATA_HI = 3'd3,
        ST_DATA_LO = 3'd4,
        ST_CSUM    = 3'd5
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_CSUM     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_DISABLED = 2'd3;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/serial_loader_timeout.sv
// Inter-byte watchdog for the serial loader: a down-counter reloaded on every
// restart (and whenever it is not running) that flags expiry once CYCLES
// clocks have elapsed without a restart.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   i_run       : count only while high (loader is inside a frame)
//   i_restart   : reload the counter (a byte arrived)
//   o_expire    : high while the budget is exhausted; a same-cycle restart wins
module loader_timeout #(
    parameter int unsigned CYCLES = 5_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_run,
    input  logic i_restart,
    output logic o_expire
);

    localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(CYCLES - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || i_restart || !i_run) begin
            r_count <= LOAD_VAL;
        end else if (r_count != '0) begin
            r_count <= r_count - CW'(1);
        end
    end

    // Counter is loaded with CYCLES-1 on the cycle the frame starts or a byte
    // arrives, so it reads zero exactly CYCLES clocks later.
    assign o_expire = i_run && !i_restart && (r_count == '0);

endmodule

// File: rtl/serial_loader.sv
// Serial boot loader: parses a framed byte stream from the UART receiver
//   SYNC | ADDR[23:16] ADDR[15:8] ADDR[7:0] | LEN[15:8] LEN[7:0] | N x (HI LO) | CSUM
// and writes each payload word to RAM at base+index, holding the CPU off the
// RAM bus while a frame is in progress.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   enable           : loader armed; low aborts any frame in progress
//   rx_data/rx_valid : received byte and its one-cycle strobe
//   ram_addr/ram_wdata/ram_we/ram_be : registered RAM write port
//   cpu_hold         : high while a frame is being parsed
//   done / err       : one-cycle result pulses; err_code holds the cause
//   words_written    : words written in the current / last frame
module serial_loader
    import serial_loader_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = serial_loader_pkg::SYNC_BYTE,
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
    parameter int unsigned ADDR_W         = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_wdata,
    output logic              ram_we,
    output logic [1:0]        ram_be,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [15:0]       words_written
);

    state_t            r_state;
    state_t            w_state_next;

    logic [1:0]        r_byte_cnt;
    logic [ADDR_W-1:0] r_base;
    logic [15:0]       r_len;
    logic [15:0]       r_index;
    logic [7:0]        r_hi;
    logic [7:0]        r_csum;

    logic              w_expire;
    logic              w_sync_accept;
    logic              w_byte_take;
    logic              w_write_set;
    logic              w_done_set;
    logic              w_err_set;
    logic [1:0]        w_err_code_val;
    logic [ADDR_W-1:0] w_addr_sum;
    logic [15:0]       w_len_full;

    loader_timeout #(
        .CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .i_run    (r_state != ST_IDLE),
        .i_restart(rx_valid),
        .o_expire (w_expire)
    );

    // Address arithmetic is naturally modulo 2^ADDR_W.
    assign w_addr_sum = r_base + ADDR_W'(r_index);
    assign w_len_full = {r_len[7:0], rx_data};

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        if (w_sync_accept) begin
            w_state_next = ST_ADDR;
        end else if (w_byte_take) begin
            case (r_state)
                ST_ADDR:    if (r_byte_cnt == 2'd2) w_state_next = ST_LEN;
                ST_LEN:     if (r_byte_cnt == 2'd1)
                                w_state_next = (w_len_full == 16'd0) ? ST_CSUM : ST_DATA_HI;
                ST_DATA_HI: w_state_next = ST_DATA_LO;
                ST_DATA_LO: w_state_next = (r_index + 16'd1 == r_len) ? ST_CSUM : ST_DATA_HI;
                ST_CSUM:    w_state_next = ST_IDLE;
                default:    w_state_next = ST_IDLE;
            endcase
        end else if (w_err_set) begin
            w_state_next = ST_IDLE;
        end
    end

    // ---------------- output / event decode ----------------
    // Priority inside a frame: disable, then an arriving byte, then timeout
    // (a byte landing on the expiry cycle keeps the frame alive).
    always_comb begin
        w_sync_accept  = 1'b0;
        w_byte_take    = 1'b0;
        w_write_set    = 1'b0;
        w_done_set     = 1'b0;
        w_err_set      = 1'b0;
        w_err_code_val = ERR_NONE;
        cpu_hold       = (r_state != ST_IDLE);
        if (r_state == ST_IDLE) begin
            w_sync_accept = enable && rx_valid && (rx_data == SYNC_BYTE);
        end else if (!enable) begin
            w_err_set      = 1'b1;
            w_err_code_val = ERR_DISABLED;
        end else if (rx_valid) begin
            w_byte_take = 1'b1;
            if (r_state == ST_DATA_LO) begin
                w_write_set = 1'b1;
            end
            if (r_state == ST_CSUM) begin
                if (rx_data == r_csum) begin
                    w_done_set = 1'b1;
                end else begin
                    w_err_set      = 1'b1;
                    w_err_code_val = ERR_CSUM;
                end
            end
        end else if (w_expire) begin
            w_err_set      = 1'b1;
            w_err_code_val = ERR_TIMEOUT;
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_addr      <= '0;
            ram_wdata     <= '0;
            ram_we        <= 1'b0;
            ram_be        <= 2'b00;
            done          <= 1'b0;
            err           <= 1'b0;
            err_code      <= ERR_NONE;
            words_written <= '0;
            r_byte_cnt    <= '0;
            r_base        <= '0;
            r_len         <= '0;
            r_index       <= '0;
            r_hi          <= '0;
            r_csum        <= '0;
        end else begin
            ram_we <= w_write_set;
            ram_be <= w_write_set ? 2'b11 : 2'b00;
            done   <= w_done_set;
            err    <= w_err_set;
            if (w_err_set) begin
                err_code <= w_err_code_val;
            end

            if (w_sync_accept) begin
                words_written <= '0;
                err_code      <= ERR_NONE;
                r_byte_cnt    <= '0;
                r_base        <= '0;
                r_len         <= '0;
                r_index       <= '0;
                r_csum        <= '0;
            end

            if (w_byte_take) begin
                case (r_state)
                    ST_ADDR: begin
                        // Shift in big-endian; bits above ADDR_W fall off the top.
                        r_base     <= ADDR_W'({r_base, rx_data});
                        r_byte_cnt <= (r_byte_cnt == 2'd2) ? 2'd0 : r_byte_cnt + 2'd1;
                    end
                    ST_LEN: begin
                        r_len      <= w_len_full;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                    end
                    ST_DATA_HI: begin
                        r_hi   <= rx_data;
                        r_csum <= r_csum + rx_data;
                    end
                    ST_DATA_LO: begin
                        r_csum        <= r_csum + rx_data;
                        ram_addr      <= w_addr_sum;
                        ram_wdata     <= {r_hi, rx_data};
                        r_index       <= r_index + 16'd1;
                        words_written <= words_written + 16'd1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
